// File: rtl/instr_mem_loader.sv
// Write-side front end for the byte-addressed instruction memory: parses a framed byte
// stream (16-bit word count, payload, 8-bit additive checksum) into byte writes.
module instr_mem_loader #(
  parameter int unsigned MEM_SIZE  = 1024,
  parameter int unsigned ADDR_W    = $clog2(MEM_SIZE),
  parameter int unsigned MAX_WORDS = MEM_SIZE / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_in_valid,
  output logic              byte_in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;

  logic              ready_d, hold_d, done_d, error_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic [15:0]       words_d;

  logic        accept;
  logic [15:0] len_full;
  logic [17:0] last_idx;
  logic        last_byte;

  assign accept    = byte_in_valid && byte_in_ready;
  assign len_full  = {len_q[15:8], byte_in};
  // Index of the final payload byte; only consulted in DATA, where len_q >= 1.
  assign last_idx  = {len_q, 2'b00} - 18'd1;
  assign last_byte = (18'(cnt_q) == last_idx);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) begin
          if (32'(len_full) > MAX_WORDS) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept && last_byte) state_d = StCsum;
      end
      StCsum: begin
        if (accept) state_d = (byte_in == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    len_d       = len_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    words_d     = words_loaded;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          cnt_d  = '0;
          csum_d = '0;
        end
      end
      StLenHi: begin
        if (accept) len_d[15:8] = byte_in;
      end
      StLenLo: begin
        if (accept) len_d[7:0] = byte_in;
      end
      StData: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = byte_in;
          cnt_d       = cnt_q + ADDR_W'(1);
          csum_d      = csum_q + byte_in;
        end
      end
      StCsum: begin
        if (accept && (byte_in == csum_q)) words_d = len_q;
      end
      default: ;
    endcase
    ready_d = (state_d == StLenHi) || (state_d == StLenLo) ||
              (state_d == StData)  || (state_d == StCsum);
    // ERR keeps the pipeline stalled so a partial image never runs.
    hold_d  = ready_d || (state_d == StErr);
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= '0;
      cnt_q         <= '0;
      csum_q        <= '0;
      byte_in_ready <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
    end else begin
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      byte_in_ready <= ready_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      cpu_hold      <= hold_d;
      done          <= done_d;
      error         <= error_d;
      words_loaded  <= words_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: a frame-level model predicts every output each cycle,
// with literal checks on the directed frames.
module tb_instr_mem_loader;

  localparam int unsigned MEM_SIZE  = 1024;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_in_valid = 1'b0;
  logic              byte_in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  instr_mem_loader #(
    .MEM_SIZE (MEM_SIZE),
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_in      (byte_in),
    .byte_in_valid(byte_in_valid),
    .byte_in_ready(byte_in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a load is "active" from start until the frame's final byte, and
  // each accepted byte is classified purely by its position in the frame.
  bit        m_active, m_done, m_err, m_we;
  int        m_idx, m_len, m_addr;
  logic [7:0]  m_sum, m_data;
  logic [15:0] m_words;

  initial begin
    forever begin
      @(posedge clk);
      m_we = 1'b0;
      if (rst) begin
        m_active = 0; m_done = 0; m_err = 0; m_idx = 0; m_len = 0; m_sum = 0; m_words = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_done = 0; m_err = 0; m_idx = 0; m_sum = 0; m_len = 0;
        end
      end else if (byte_in_valid) begin
        if (m_idx == 0) begin
          m_len = int'(byte_in) * 256;
        end else if (m_idx == 1) begin
          m_len = m_len + int'(byte_in);
          if (m_len > int'(MAX_WORDS)) begin
            m_active = 0; m_err = 1;
          end
        end else if (m_idx < 4 * m_len + 2) begin
          m_we = 1; m_addr = m_idx - 2; m_data = byte_in; m_sum = m_sum + byte_in;
        end else begin
          m_active = 0;
          if (byte_in == m_sum) begin
            m_done = 1; m_words = 16'(m_len);
          end else begin
            m_err = 1;
          end
        end
        m_idx++;
      end
    end
  end

  int          wr_addr_log[$];
  logic [7:0]  wr_data_log[$];

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("ready", 32'(byte_in_ready), 32'(m_active));
        check("cpu_hold", 32'(cpu_hold), 32'(m_active || m_err));
        check("done", 32'(done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        check("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we && mem_we) begin
          check("mem_addr", 32'(mem_addr), 32'(m_addr));
          check("mem_wdata", 32'(mem_wdata), 32'(m_data));
        end
        if (m_done) check("words_loaded", 32'(words_loaded), 32'(m_words));
      end
      if (mem_we === 1'b1) begin
        wr_addr_log.push_back(int'(mem_addr));
        wr_data_log.push_back(mem_wdata);
      end
    end
  end

  logic [7:0] frame[$];

  task automatic build(input int words, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] w;
    w = 16'(words);
    frame = {};
    frame.push_back(w[15:8]);
    frame.push_back(w[7:0]);
    if (words <= int'(MAX_WORDS)) begin
      s = 8'h00;
      for (int i = 0; i < 4 * words; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        s = s + b;
      end
      frame.push_back(corrupt ? s + 8'h01 : s);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_in_valid = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    byte_in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents b until the DUT is ready; the following rising edge accepts it.
  task automatic send(input logic [7:0] b, input bit gaps, input bit st);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        byte_in_valid = 1'b0;
        byte_in = 8'($urandom);
        start = 1'b0;
      end
    end
    n = 0;
    forever begin
      @(negedge clk);
      byte_in_valid = 1'b1;
      byte_in = b;
      start = st;
      if (byte_in_ready) break;
      n++;
      if (n > 50) begin
        bad++;
        total++;
        $display("FAIL send_timeout: ready stuck low, want 1 at %0t", $time);
        break;
      end
    end
  endtask

  task automatic send_frame(input bit gaps, input bit st_mid);
    do_start();
    for (int i = 0; i < frame.size(); i++) send(frame[i], gaps, st_mid && (i > 2));
    idle(3);
  endtask

  task automatic hold_junk(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_in_valid = 1'b1;
      byte_in = 8'($urandom);
      start = 1'b0;
    end
    idle(1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);

    // Single word, continuous valid
    wr_addr_log = {}; wr_data_log = {};
    frame = {8'h00, 8'h01, 8'h80, 8'h20, 8'h00, 8'h06, 8'hA6};
    send_frame(1'b0, 1'b0);
    check("t1_nwr", 32'(wr_addr_log.size()), 32'd4);
    check("t1_a0", 32'(wr_addr_log[0]), 32'd0);
    check("t1_d0", 32'(wr_data_log[0]), 32'h80);
    check("t1_a3", 32'(wr_addr_log[3]), 32'd3);
    check("t1_d3", 32'(wr_data_log[3]), 32'h06);
    check("t1_done", 32'(done), 32'd1);
    check("t1_words", 32'(words_loaded), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);

    // Bad checksum, then recover
    wr_addr_log = {}; wr_data_log = {};
    frame = {8'h00, 8'h01, 8'h80, 8'h20, 8'h00, 8'h06, 8'hA7};
    send_frame(1'b0, 1'b0);
    check("t2_nwr", 32'(wr_addr_log.size()), 32'd4);
    check("t2_err", 32'(error), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_hold", 32'(cpu_hold), 32'd1);
    frame = {8'h00, 8'h01, 8'h80, 8'h20, 8'h00, 8'h06, 8'hA6};
    send_frame(1'b0, 1'b0);
    check("t2_redone", 32'(done), 32'd1);
    check("t2_reerr", 32'(error), 32'd0);

    // Length overflow
    wr_addr_log = {}; wr_data_log = {};
    frame = {8'h01, 8'h01};
    send_frame(1'b0, 1'b0);
    hold_junk(5);
    check("t3_err", 32'(error), 32'd1);
    check("t3_ready", 32'(byte_in_ready), 32'd0);
    check("t3_nwr", 32'(wr_addr_log.size()), 32'd0);

    // Zero-length frames
    frame = {8'h00, 8'h00, 8'h00};
    send_frame(1'b0, 1'b0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_words", 32'(words_loaded), 32'd0);
    check("t4_nwr", 32'(wr_addr_log.size()), 32'd0);
    hold_junk(4);
    frame = {8'h00, 8'h00, 8'h01};
    send_frame(1'b0, 1'b0);
    check("t4_err", 32'(error), 32'd1);

    // Backpressure and gaps
    hold_junk(4);
    wr_addr_log = {}; wr_data_log = {};
    build(2, 1'b0);
    send_frame(1'b1, 1'b0);
    check("t5_nwr", 32'(wr_addr_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr_log.size(); i++) begin
      check("t5_addr", 32'(wr_addr_log[i]), 32'(i));
      check("t5_data", 32'(wr_data_log[i]), 32'(frame[i + 2]));
    end
    check("t5_done", 32'(done), 32'd1);

    // Start pulses during DATA are ignored
    build(3, 1'b0);
    send_frame(1'b1, 1'b1);
    check("t6_done", 32'(done), 32'd1);
    check("t6_words", 32'(words_loaded), 32'd3);

    // Reset after the third payload byte
    build(2, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) send(frame[i], 1'b0, 1'b0);
    @(negedge clk);
    byte_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_ready", 32'(byte_in_ready), 32'd0);
    check("t7_we", 32'(mem_we), 32'd0);
    check("t7_addr", 32'(mem_addr), 32'd0);
    check("t7_wdata", 32'(mem_wdata), 32'd0);
    check("t7_hold", 32'(cpu_hold), 32'd0);
    check("t7_words", 32'(words_loaded), 32'd0);
    wr_addr_log = {}; wr_data_log = {};
    build(2, 1'b0);
    send_frame(1'b0, 1'b0);
    check("t7_first", 32'(wr_addr_log[0]), 32'd0);
    check("t7_done", 32'(done), 32'd1);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, 6));
      build(w, $urandom_range(0, 3) == 0);
      send_frame($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) hold_junk(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
